// File: rtl/tlc_pkg.sv
// Shared traffic-light constants: light codes, timing constants, count width
// and the sensor debounce state encoding.
package tlc_pkg;

  localparam int unsigned CNT_W = 31;

  typedef enum logic [1:0] {
    RED    = 2'b01,
    YELLOW = 2'b10,
    GREEN  = 2'b11
  } light_t;

  // Cycle counts at a 50 MHz system clock.
  localparam logic [CNT_W-1:0] ONE_SEC     = 31'd50_000_000;
  localparam logic [CNT_W-1:0] THREE_SEC   = 31'd150_000_000;
  localparam logic [CNT_W-1:0] FIFTEEN_SEC = 31'd750_000_000;
  localparam logic [CNT_W-1:0] THIRTY_SEC  = 31'd1_500_000_000;

  typedef enum logic [1:0] {
    DB_LOW,
    DB_CHK_HIGH,
    DB_HIGH,
    DB_CHK_LOW
  } db_state_t;

endpackage

// File: rtl/tlc_debounce.sv
// Two-flop synchroniser plus four-state debounce FSM for the farm-road sensor.
module tlc_debounce
  import tlc_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic raw,
  output logic db
);

  // The stable state is entered on the edge where the count would reach
  // DEBOUNCE_CYCLES-1, so the new level must be seen for DEBOUNCE_CYCLES samples.
  localparam logic [15:0] LAST = 16'(DEBOUNCE_CYCLES - 2);

  logic        sync_q1;
  logic        sync;
  db_state_t   state;
  logic [15:0] cnt;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      sync_q1 <= 1'b0;
      sync    <= 1'b0;
      state   <= DB_LOW;
      cnt     <= '0;
      db      <= 1'b0;
    end else begin
      sync_q1 <= raw;
      sync    <= sync_q1;
      case (state)
        DB_LOW: begin
          if (sync) begin
            state <= DB_CHK_HIGH;
            cnt   <= '0;
          end
        end
        DB_CHK_HIGH: begin
          if (!sync) begin
            state <= DB_LOW;
            cnt   <= '0;
          end else if (cnt == LAST) begin
            state <= DB_HIGH;
            cnt   <= '0;
            db    <= 1'b1;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        DB_HIGH: begin
          if (!sync) begin
            state <= DB_CHK_LOW;
            cnt   <= '0;
          end
        end
        DB_CHK_LOW: begin
          if (sync) begin
            state <= DB_HIGH;
            cnt   <= '0;
          end else if (cnt == LAST) begin
            state <= DB_LOW;
            cnt   <= '0;
            db    <= 1'b0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: begin
          state <= DB_LOW;
          cnt   <= '0;
          db    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/tlc_sensor_timer.sv
// Saturating phase timer and conditioned farm-road vehicle request.
// Define TLC_REQ_LATCH_EN to latch requests until the farm light turns green.
module tlc_sensor_timer
  import tlc_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CNT_W           = tlc_pkg::CNT_W
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             farmSensorRaw,
  input  logic             RstCount,
  input  logic [1:0]       farmSignal,
  output logic [CNT_W-1:0] Count,
  output logic             farmSensor
);

  logic db;

  tlc_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db (
    .Clk  (Clk),
    .Rst_n(Rst_n),
    .raw  (farmSensorRaw),
    .db   (db)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      Count <= '0;
    end else if (RstCount) begin
      Count <= '0;
    end else if (Count != '1) begin
      Count <= Count + 1'b1;
    end
  end

`ifdef TLC_REQ_LATCH_EN
  logic req_latch;
  logic db_q;
  logic latch_d;

  // Green clear overrides a simultaneous db rising edge; the output uses the
  // next latch value so a green light drops the request one edge later.
  always_comb begin
    latch_d = req_latch;
    if (db && !db_q) latch_d = 1'b1;
    if (farmSignal == 2'(GREEN)) latch_d = 1'b0;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      req_latch  <= 1'b0;
      db_q       <= 1'b0;
      farmSensor <= 1'b0;
    end else begin
      req_latch  <= latch_d;
      db_q       <= db;
      farmSensor <= latch_d | db;
    end
  end
`else
  logic unused_farm_signal;
  assign unused_farm_signal = ^farmSignal;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      farmSensor <= 1'b0;
    end else begin
      farmSensor <= db;
    end
  end
`endif

endmodule

// File: tb/tb_tlc_sensor_timer.sv
// Bench for tlc_sensor_timer (DEBOUNCE_CYCLES=4, CNT_W=8); directed steps plus
// randomized traffic checked against a run-length behavioural model.
module tb_tlc_sensor_timer;
  import tlc_pkg::*;

  localparam int N = 4;

  logic       Clk = 1'b0;
  logic       Rst_n = 1'b0;
  logic       farmSensorRaw = 1'b0;
  logic       RstCount = 1'b0;
  logic [1:0] farmSignal = 2'b01;
  logic [7:0] Count;
  logic       farmSensor;

  int checks = 0;
  int errors = 0;

  tlc_sensor_timer #(
    .DEBOUNCE_CYCLES(N),
    .CNT_W(8)
  ) dut (
    .Clk          (Clk),
    .Rst_n        (Rst_n),
    .farmSensorRaw(farmSensorRaw),
    .RstCount     (RstCount),
    .farmSignal   (farmSignal),
    .Count        (Count),
    .farmSensor   (farmSensor)
  );

  always #5 Clk = ~Clk;

  // Reference model: raw is seen two edges late; the level flips once N
  // consecutive samples disagree with it; the output shows the level one edge later.
  int   cnt_m = 0;
  bit   fs_m = 0;
  bit   lvl_m = 0;
  bit   lvl_prev = 0;
  bit   latch_m = 0;
  int   run_m = 0;
  bit   raw_hist[$];

  always @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cnt_m = 0; fs_m = 0; lvl_m = 0; lvl_prev = 0; latch_m = 0; run_m = 0;
      raw_hist = '{0, 0};
    end else begin
      bit seen;
      cnt_m = RstCount ? 0 : ((cnt_m >= 255) ? 255 : cnt_m + 1);
`ifdef TLC_REQ_LATCH_EN
      begin
        bit nl;
        nl = (farmSignal == 2'b11) ? 1'b0 : ((lvl_m && !lvl_prev) ? 1'b1 : latch_m);
        latch_m = nl;
        fs_m = nl | lvl_m;
      end
`else
      fs_m = lvl_m;
`endif
      lvl_prev = lvl_m;
      seen = raw_hist.pop_front();
      run_m = (seen != lvl_m) ? run_m + 1 : 0;
      if (run_m == N) begin
        lvl_m = !lvl_m;
        run_m = 0;
      end
      raw_hist.push_back(farmSensorRaw);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge Clk);
    check("count_model", 64'(Count), 64'(cnt_m));
    check("sensor_model", 64'(farmSensor), 64'(fs_m));
  endtask

  initial begin
    int hold;
    raw_hist = '{0, 0};

    #3;
    check("reset_count", 64'(Count), 64'd0);
    check("reset_sensor", 64'(farmSensor), 64'd0);
    @(negedge Clk);
    Rst_n = 1'b1;
    repeat (3) cyc();

    // Clean rising edge: output changes exactly 7 edges after the first sample.
    farmSensorRaw = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      cyc();
      check("latency", 64'(farmSensor), (k == 7) ? 64'd1 : 64'd0);
    end
    repeat (13) cyc();
    farmSensorRaw = 1'b0;
    repeat (10) cyc();
    check("fall_low", 64'(farmSensor), 64'd0);

    // Three-cycle glitch is rejected.
    farmSensorRaw = 1'b1;
    repeat (3) cyc();
    farmSensorRaw = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cyc();
      check("glitch", 64'(farmSensor), 64'd0);
    end
    check("glitch_state", 64'(dut.u_db.state), 64'(DB_LOW));

    // Saturation and clear.
    RstCount = 1'b1;
    cyc();
    RstCount = 1'b0;
    repeat (300) cyc();
    check("saturate", 64'(Count), 64'd255);
    RstCount = 1'b1;
    cyc();
    RstCount = 1'b0;
    check("clear_sat", 64'(Count), 64'd0);
    cyc();
    check("after_clear1", 64'(Count), 64'd1);
    cyc();
    check("after_clear2", 64'(Count), 64'd2);
    RstCount = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cyc();
      check("clear_held", 64'(Count), 64'd0);
    end
    RstCount = 1'b0;

`ifdef TLC_REQ_LATCH_EN
    // Latched request survives the sensor dropping until the light turns green.
    farmSignal = 2'b01;
    farmSensorRaw = 1'b1;
    repeat (10) cyc();
    farmSensorRaw = 1'b0;
    repeat (15) cyc();
    check("latch_hold", 64'(farmSensor), 64'd1);
    farmSignal = 2'b11;
    cyc();
    check("latch_green_clear", 64'(farmSensor), 64'd0);
    farmSignal = 2'b01;
    repeat (3) cyc();
    // Green coincides with the db rising edge: clear wins.
    farmSensorRaw = 1'b1;
    repeat (5) cyc();
    farmSignal = 2'b11;
    repeat (3) cyc();
    farmSignal = 2'b01;
    check("db_follow_high", 64'(farmSensor), 64'd1);
    repeat (2) cyc();
    farmSensorRaw = 1'b0;
    repeat (12) cyc();
    check("set_clear_same", 64'(farmSensor), 64'd0);
`endif

    // Asynchronous reset in the middle of DB_CHK_HIGH with Count at 100.
    RstCount = 1'b1;
    cyc();
    RstCount = 1'b0;
    repeat (97) cyc();
    farmSensorRaw = 1'b1;
    repeat (3) cyc();
    check("pre_reset_count", 64'(Count), 64'd100);
    check("pre_reset_state", 64'(dut.u_db.state), 64'(DB_CHK_HIGH));
    #2;
    Rst_n = 1'b0;
    #1;
    check("async_count", 64'(Count), 64'd0);
    check("async_sensor", 64'(farmSensor), 64'd0);
    check("async_state", 64'(dut.u_db.state), 64'(DB_LOW));
    @(negedge Clk);
    farmSensorRaw = 1'b0;
    Rst_n = 1'b1;
    cyc();
    check("resume_count", 64'(Count), 64'd1);

    // Randomized traffic against the model.
    hold = 0;
    for (int k = 0; k < 600; k++) begin
      if (hold == 0) begin
        farmSensorRaw = 1'($urandom_range(0, 1));
        hold = $urandom_range(1, 9);
      end
      hold--;
      RstCount = ($urandom_range(0, 39) == 0);
      farmSignal = 2'($urandom_range(1, 3));
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tlc_sensor_timer.md
TLC_SENSOR_TIMER -- requirements
Module: tlc_sensor_timer

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 50000, consecutive cycles a changed sensor level must persist (1 ms at 50 MHz); legal range 2..65535.
REQ-002 SHALL have parameter CNT_W, default 31, width of Count.
REQ-003 SHALL have port Clk  input  1  single system clock; all state on posedge.
REQ-004 SHALL have port Rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port farmSensorRaw  input  1  unsynchronised farm-road vehicle detector.
REQ-006 SHALL have port RstCount  input  1  count-clear request from controller FSM.
REQ-007 SHALL have port farmSignal  input  2  current farm light code from controller (11 green, 10 yellow, 01 red).
REQ-008 SHALL have port Count  output  CNT_W  elapsed clock cycles since last clear.
REQ-009 SHALL have port farmSensor  output  1  conditioned vehicle request to controller FSM.

Function
REQ-010 SHALL pass farmSensorRaw through a two-flop synchroniser; its second-stage output is the sync signal.
REQ-011 SHALL debounce sync with a four-state FSM: DB_LOW, DB_CHK_HIGH, DB_HIGH, DB_CHK_LOW.
REQ-012 SHALL move DB_LOW->DB_CHK_HIGH on sync=1, and DB_HIGH->DB_CHK_LOW on sync=0; the debounce counter is cleared on entry.
REQ-013 SHALL, in a CHK state, increment the counter each cycle while sync holds the new level, and return to the origin stable state with the counter cleared if sync reverts.
REQ-014 SHALL enter the new stable state when the counter reaches DEBOUNCE_CYCLES-1 with sync still at the new level; the debounced level (db) is 1 in DB_HIGH and DB_CHK_LOW.
REQ-015 SHALL register farmSensor, giving latency exactly DEBOUNCE_CYCLES+3 edges from the first edge sampling a raw change to the farmSensor change.
REQ-016 SHALL ignore raw pulses or gaps shorter than DEBOUNCE_CYCLES cycles, with farmSensor unchanged.
REQ-017 SHALL increment Count by 1 each cycle while RstCount=0.
REQ-018 SHALL saturate Count at 2^CNT_W-1, never wrapping to 0.
REQ-019 SHALL make Count 0 on the edge after any edge sampling RstCount=1, including at saturation.
REQ-020 SHALL keep the counter clear dominant if RstCount is held high, so Count stays 0.

Reset
REQ-021 SHALL, on Rst_n low, asynchronously set Count=0, farmSensor=0, synchroniser flops=0, debounce FSM=DB_LOW, debounce counter=0 and request latch=0.
REQ-022 SHALL resume counting from 0 on the first edge after Rst_n deasserts; a reset mid-debounce discards the partial count.

Configuration
REQ-023 SHALL, with TLC_REQ_LATCH_EN defined, set the request latch on a db rising edge and clear it while farmSignal=11; farmSensor = latch OR db.
REQ-024 SHALL let clear win when set and clear occur in the same cycle under TLC_REQ_LATCH_EN.
REQ-025 SHALL, without TLC_REQ_LATCH_EN, make farmSensor = db registered, with no latch logic present and farmSignal unused.

Structure
REQ-026 SHALL take light codes (GREEN/YELLOW/RED), timing constants (ONE_SEC, THREE_SEC, FIFTEEN_SEC, THIRTY_SEC) and CNT_W from shared package tlc_pkg, which the controller FSM also uses.
REQ-027 SHALL place the synchroniser and debounce FSM in sub-module tlc_debounce (parameter DEBOUNCE_CYCLES; ports Clk, Rst_n, raw in, db out).

Verification (DEBOUNCE_CYCLES=4, CNT_W=8)
REQ-028 SHALL cover: raw 0->1 held 20 cycles -> farmSensor=1 exactly 7 edges after the first sampling edge.
REQ-029 SHALL cover: raw high 3 cycles then low -> farmSensor stays 0; debounce FSM returns to DB_LOW.
REQ-030 SHALL cover: RstCount low for 300 cycles -> Count saturates at 255; RstCount pulse 1 cycle -> Count=0 next edge, then 1, 2...
REQ-031 SHALL cover, with TLC_REQ_LATCH_EN: raw high 10 cycles then low, farmSignal=01 -> farmSensor stays 1; farmSignal=11 -> farmSensor=0 one edge later.
REQ-032 SHALL cover, with TLC_REQ_LATCH_EN: db rises in the same cycle farmSignal=11 -> latch stays 0 and farmSensor follows db only.
REQ-033 SHALL cover: Rst_n low mid-DB_CHK_HIGH with Count=100 -> Count=0 and farmSensor=0 immediately, without waiting for Clk.
